// File: rtl/commons.sv
// Shared definitions for the spelled-digit decoder: FSM state type,
// history depth, character constants and the spelled-word patterns.
// Optional build macro DIGIT_WORD_ZERO_EN (consumed by digit_word_match).
package commons;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dw_state_t;

  localparam int unsigned DW_HIST_LEN = 4;
  localparam int unsigned DW_CHAR_W   = 8;

  // Element 0 is the newest accepted char, so {hist, char} reads oldest..newest.
  typedef logic [DW_HIST_LEN-1:0][DW_CHAR_W-1:0] dw_hist_t;

  localparam logic [DW_CHAR_W-1:0] DW_NL         = 8'h0A;
  localparam logic [DW_CHAR_W-1:0] DW_ASCII_ZERO = 8'h30;

  localparam logic [23:0] DW_ONE   = "one";
  localparam logic [23:0] DW_TWO   = "two";
  localparam logic [23:0] DW_SIX   = "six";
  localparam logic [31:0] DW_FOUR  = "four";
  localparam logic [31:0] DW_FIVE  = "five";
  localparam logic [31:0] DW_NINE  = "nine";
  localparam logic [31:0] DW_ZERO  = "zero";
  localparam logic [39:0] DW_THREE = "three";
  localparam logic [39:0] DW_SEVEN = "seven";
  localparam logic [39:0] DW_EIGHT = "eight";

  function automatic logic [DW_CHAR_W-1:0] dw_digit_char(input logic [3:0] digit);
    return DW_ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/digit_word_match.sv
// Combinational suffix matcher: checks history+char for a spelled digit.
// Build macro DIGIT_WORD_ZERO_EN adds "zero" to the recognised words.
module digit_word_match
  import commons::*;
(
  input  dw_hist_t               i_hist,
  input  logic [DW_CHAR_W-1:0]   i_char,
  output logic                   o_hit,
  output logic [3:0]             o_digit
);

  logic [39:0] w_win;

  assign w_win = {i_hist, i_char};

  // Suffix compare; no word is a suffix of another, so order is irrelevant.
  always_comb begin
    o_hit   = 1'b0;
    o_digit = '0;
    if (w_win[23:0] == DW_ONE) begin
      o_hit = 1'b1; o_digit = 4'd1;
    end else if (w_win[23:0] == DW_TWO) begin
      o_hit = 1'b1; o_digit = 4'd2;
    end else if (w_win[39:0] == DW_THREE) begin
      o_hit = 1'b1; o_digit = 4'd3;
    end else if (w_win[31:0] == DW_FOUR) begin
      o_hit = 1'b1; o_digit = 4'd4;
    end else if (w_win[31:0] == DW_FIVE) begin
      o_hit = 1'b1; o_digit = 4'd5;
    end else if (w_win[23:0] == DW_SIX) begin
      o_hit = 1'b1; o_digit = 4'd6;
    end else if (w_win[39:0] == DW_SEVEN) begin
      o_hit = 1'b1; o_digit = 4'd7;
    end else if (w_win[39:0] == DW_EIGHT) begin
      o_hit = 1'b1; o_digit = 4'd8;
    end else if (w_win[31:0] == DW_NINE) begin
      o_hit = 1'b1; o_digit = 4'd9;
    end
`ifdef DIGIT_WORD_ZERO_EN
    else if (w_win[31:0] == DW_ZERO) begin
      o_hit = 1'b1; o_digit = 4'd0;
    end
`else
`endif
  end

endmodule

// File: rtl/digit_word_decoder.sv
// Streaming decoder replacing spelled digits ("one".."nine") with ASCII
// digits, one cycle of latency, with a saturating substitution counter.
// Build macro DIGIT_WORD_ZERO_EN enables "zero" -> "0".
module digit_word_decoder
  import commons::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  logic [DW_CHAR_W-1:0] char_i,
  output logic                 run_o,
  output logic [DW_CHAR_W-1:0] char_o,
  output logic [15:0]          matches_o
);

  dw_state_t            r_state;
  dw_hist_t             r_hist;
  logic                 r_run;
  logic [DW_CHAR_W-1:0] r_char;
  logic [15:0]          r_matches;

  dw_state_t            w_state_nxt;
  dw_hist_t             w_hist_cur;
  dw_hist_t             w_hist_nxt;
  logic [DW_CHAR_W-1:0] w_char_nxt;
  logic [15:0]          w_matches_nxt;
  logic                 w_hit;
  logic [3:0]           w_digit;

  // History only carries meaning inside a run; outside it the window is empty.
  assign w_hist_cur = (r_state == RUN) ? r_hist : '0;

  digit_word_match u_match (
    .i_hist  (w_hist_cur),
    .i_char  (char_i),
    .o_hit   (w_hit),
    .o_digit (w_digit)
  );

  // State and output registers; synchronous reset wins over run_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_hist    <= '0;
      r_run     <= 1'b0;
      r_char    <= '0;
      r_matches <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hist    <= w_hist_nxt;
      r_run     <= run_i;
      r_char    <= w_char_nxt;
      r_matches <= w_matches_nxt;
    end
  end

  // Next-state, history shift, translated char and counter update.
  always_comb begin
    w_state_nxt   = r_state;
    w_hist_nxt    = '0;
    w_char_nxt    = '0;
    w_matches_nxt = r_matches;

    case (r_state)
      IDLE:    if (run_i)  w_state_nxt = RUN;
      RUN:     if (!run_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (run_i) begin
      // Raw char is pushed (not the digit) so overlapping words still decode.
      if (char_i != DW_NL) begin
        w_hist_nxt = {w_hist_cur[DW_HIST_LEN-2:0], char_i};
      end
      w_char_nxt = w_hit ? dw_digit_char(w_digit) : char_i;
      if (w_hit && (r_matches != '1)) begin
        w_matches_nxt = r_matches + 16'd1;
      end
    end
  end

  assign run_o     = r_run;
  assign char_o    = r_char;
  assign matches_o = r_matches;

endmodule

// File: doc/digit_word_decoder.md
DIGIT_WORD_DECODER -- requirements
Module: digit_word_decoder

Interface
REQ-001 SHALL have port clk_i  in  1  single clock; all logic rising-edge.
REQ-002 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port run_i  in  1  stream active; each cycle with run_i=1 carries one valid char.
REQ-004 SHALL have port char_i  in  8  ASCII input char.
REQ-005 SHALL have port run_o  out  1  run_i delayed 1 cycle; drives the downstream calibration-sum stage run input.
REQ-006 SHALL have port char_o  out  8  translated char, aligned with run_o.
REQ-007 SHALL have port matches_o  out  16  count of spelled-digit substitutions since reset, saturating.

Function
REQ-008 SHALL implement states IDLE and RUN.
REQ-009 SHALL go IDLE->RUN on run_i=1; that cycle's char is processed.
REQ-010 SHALL go RUN->IDLE on run_i=0; history is cleared in the same cycle.
REQ-011 SHALL keep a 4-char history (the last 4 accepted chars, newest last), updated on every accepted char.
REQ-012 On an accepted char, SHALL test history+char_i for a suffix equal to "one","two","three","four","five","six","seven","eight","nine" (lowercase only).
REQ-013 On a match, SHALL register char_o = ASCII digit ("1".."9"); otherwise char_o = char_i unchanged.
REQ-014 Latency char_i->char_o SHALL be exactly 1 cycle.
REQ-015 run_o SHALL equal the previous cycle's run_i.
REQ-016 SHALL push the raw char_i, never the substituted digit, into the history, so overlaps decode: "eightwo" -> 8 then 2 on the final "t" and "o".
REQ-017 On char_i="\n", SHALL pass "\n" through and clear history after the cycle; words never span lines.
REQ-018 At most one match SHALL be possible per char; suffixes are mutually exclusive.
REQ-019 With run_i=0, SHALL hold char_o=8'h00 from the next cycle.
REQ-020 matches_o SHALL increment by 1 per match and saturate at 16'hFFFF.
REQ-021 Digits "0".."9" in char_i SHALL pass through unchanged and be pushed into the history.

Reset
REQ-022 rst_i=1 at a clock edge SHALL force state=IDLE, history=0, run_o=0, char_o=8'h00, matches_o=0.
REQ-023 Reset mid-line SHALL discard a partial word; the first char after reset starts with empty history.
REQ-024 Reset SHALL dominate run_i in the same cycle.

Configuration
REQ-025 With macro DIGIT_WORD_ZERO_EN defined, "zero" SHALL also match, giving char_o="0" and incrementing matches_o.
REQ-026 Without DIGIT_WORD_ZERO_EN, "zero" SHALL pass through as plain letters.

Structure
REQ-027 The following SHALL live in shared package commons:
- dw_state_t {IDLE, RUN}
- constant DW_HIST_LEN=4
- the spelled-word constants
REQ-028 Word comparison SHALL be a combinational sub-module digit_word_match: inputs history+char, outputs hit and digit[3:0].

Verification
REQ-029 Stream "two1nine\n" -> char_o sequence "tw21nin9\n", matches_o=2, each char 1 cycle after input.
REQ-030 Stream "eightwothree\n" -> 8 on "t", 2 on "o", 3 on final "e"; matches_o=3.
REQ-031 Stream "on\ne\n" -> no substitution, because the newline clears history; matches_o=0.
REQ-032 Stream "fiv", run_i=0 one cycle, then "e" -> "e" passes unchanged, because a run break clears history.
REQ-033 rst_i=1 after "seve", then "n" -> "n" unchanged, matches_o=0, run_o=0 during reset cycle+1.
REQ-034 Force matches_o=16'hFFFE, feed "sixsix" -> counter reaches 16'hFFFF and holds; with DIGIT_WORD_ZERO_EN, "zero" -> "0".
